// File: rtl/window_sched_pkg.sv
// window_sched_pkg: shared types and helpers for the window scheduler.
//   op_e      : request op codes (READ, WRITE, SWAP, RSVD)
//   state_e   : scheduler FSM states (WB exists only with WINDOW_SCHED_SWAP_EN)
//   win_legal : range check of a window base against the lane range
// Optional feature macro: WINDOW_SCHED_SWAP_EN
package window_sched_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_SWAP  = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

`ifdef WINDOW_SCHED_SWAP_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_RESP = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd3
  } state_e;
`endif

  // Evaluated in 32-bit int, so sel + win - 1 cannot wrap for any SEL_W
  // used here (the sum needs only SEL_W+1 bits).
  function automatic logic win_legal(input int sel, input int lo, input int hi,
                                     input int win);
    return (lo <= sel) && ((sel + win - 1) <= hi);
  endfunction

endpackage

// File: rtl/window_sched_rr2.sv
// window_sched_rr2: two-input round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i      : request bits, one per port
//   accept_i   : a grant is being taken this cycle (update pointer)
//   gnt_o      : one-hot grant (combinational), zero when no request
// The pointer remembers the last granted port; the other port wins ties.
// After reset the pointer reads "port 1 last", giving port 0 priority.
module window_sched_rr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept_i && (gnt_o != 2'b00)) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/window_sched.sv
// window_sched: two-requester scheduler for a packed lane store accessed
// through an indexed part-select window store_q[sel +: WIN].
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : per-port request valid
//   req_ready   : per-port grant, asserted only in IDLE
//   req_op      : per-port op (0 READ, 1 WRITE, 2 SWAP, 3 reserved)
//   req_sel     : per-port window base lane index (unsigned)
//   req_wdata   : per-port write window
//   resp_valid  : response available, held until resp_ready
//   resp_ready  : response consumed
//   resp_id     : port that issued the request
//   resp_rdata  : window contents before the operation (0 on error)
//   resp_err    : out-of-range window or illegal op
//   store_q     : the packed lane store [MSB:LSB][LANE_W-1:0]
// Optional feature macro: WINDOW_SCHED_SWAP_EN (SWAP op and WB state).
// Without it, SWAP is answered like the reserved op.
module window_sched
  import window_sched_pkg::*;
#(
  parameter int MSB    = 6,
  parameter int LSB    = 0,
  parameter int LANE_W = 2,
  parameter int WIN    = 2,
  parameter int SEL_W  = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [1:0]                        req_valid,
  output logic [1:0]                        req_ready,
  input  logic [1:0][1:0]                   req_op,
  input  logic [1:0][SEL_W-1:0]             req_sel,
  input  logic [1:0][WIN*LANE_W-1:0]        req_wdata,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic                              resp_id,
  output logic [WIN*LANE_W-1:0]             resp_rdata,
  output logic                              resp_err,
  output logic [MSB:LSB][LANE_W-1:0]        store_q
);

  localparam int LO = (MSB < LSB) ? MSB : LSB;
  localparam int HI = (MSB < LSB) ? LSB : MSB;
  localparam int WW = WIN * LANE_W;

  state_e           state_q;
  op_e              op_q;
  logic [SEL_W-1:0] sel_q;
  logic [WW-1:0]    wdata_q;
  logic             id_q;

  logic [1:0]       gnt;
  logic             accept;
  logic             legal;
  logic             op_ok;
  int               base;
  logic [WW-1:0]    win_rd;

  assign accept    = (state_q == ST_IDLE) && (req_valid != 2'b00);
  assign req_ready = (state_q == ST_IDLE) ? gnt : 2'b00;

  window_sched_rr2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_valid),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  // The +: select follows the declared direction of store_q, so the same
  // expression yields little- or big-endian lane order automatically.
  assign base   = int'(sel_q);
  assign legal  = win_legal(base, LO, HI, WIN);
  assign win_rd = legal ? store_q[base +: WIN] : '0;

`ifdef WINDOW_SCHED_SWAP_EN
  assign op_ok = (op_q != OP_RSVD);
`else
  assign op_ok = (op_q == OP_READ) || (op_q == OP_WRITE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_READ;
      sel_q      <= '0;
      wdata_q    <= '0;
      id_q       <= 1'b0;
      store_q    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_id    <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state_q)
        // Accept: latch the granted port's request.
        ST_IDLE: begin
          if (accept) begin
            id_q    <= gnt[1];
            op_q    <= op_e'(req_op[gnt[1]]);
            sel_q   <= req_sel[gnt[1]];
            wdata_q <= req_wdata[gnt[1]];
            state_q <= ST_EXEC;
          end
        end
        // Execute: read old window, commit READ/WRITE, defer SWAP write.
        ST_EXEC: begin
          resp_id <= id_q;
          if (!legal || !op_ok) begin
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            resp_valid <= 1'b1;
            state_q    <= ST_RESP;
          end else begin
            resp_err   <= 1'b0;
            resp_rdata <= win_rd;
            if (op_q == OP_WRITE) store_q[base +: WIN] <= wdata_q;
`ifdef WINDOW_SCHED_SWAP_EN
            if (op_q == OP_SWAP) begin
              state_q <= ST_WB;
            end else begin
              resp_valid <= 1'b1;
              state_q    <= ST_RESP;
            end
`else
            resp_valid <= 1'b1;
            state_q    <= ST_RESP;
`endif
          end
        end
`ifdef WINDOW_SCHED_SWAP_EN
        // Write-back of the SWAP's new window.
        ST_WB: begin
          store_q[base +: WIN] <= wdata_q;
          resp_valid <= 1'b1;
          state_q    <= ST_RESP;
        end
`endif
        // Response: hold until consumed; no grant in the handshake cycle.
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
